// File: rtl/inv_sbox_iterative.sv
// inv_sbox_iterative: multi-cycle AES inverse S-box, inverse affine then x^254 by square-and-multiply.
// STEPS exponent bits are consumed per clock; latency is 8/STEPS cycles.
module inv_sbox_iterative #(
    parameter int STEPS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);
    if (STEPS != 1 && STEPS != 2 && STEPS != 4 && STEPS != 8) begin : g_bad_steps
        $error("inv_sbox_iterative: STEPS must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {IDLE, EXP, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d, acc_q, acc_d, out_data_q, out_data_d;
    logic [3:0] cnt_q, cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] acc_step, e_rem;
    logic       load;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    endfunction

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = state_q != IDLE;
    assign load      = in_valid && in_ready;

    always_comb begin
        acc_step    = acc_q;
        e_rem       = 8'hFE << cnt_q;
        state_d     = state_q;
        x_d         = x_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        // remaining exponent bits of 254 are shifted to the MSB and consumed one per step
        for (int i = 0; i < STEPS; i++) begin
            acc_step = gf_mul(acc_step, acc_step);
            if (e_rem[7]) acc_step = gf_mul(acc_step, x_q);
            e_rem = e_rem << 1;
        end
        if (state_q == EXP) begin
            acc_d = acc_step;
            cnt_d = cnt_q + 4'(STEPS);
            if (cnt_d == 4'd8) begin
                out_data_d  = acc_step;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end
        if (load) begin
            x_d     = inv_affine(in_data);
            acc_d   = 8'h01;
            cnt_d   = 4'd0;
            state_d = EXP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= 8'h00;
            acc_q       <= 8'h00;
            cnt_q       <= 4'd0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_inv_sbox_iterative.sv
// tb_inv_sbox_iterative: checks the iterative inverse S-box against a table built by brute-force
// field inversion and the forward AES affine map, plus handshake, latency and reset behaviour.
module tb_inv_sbox_iterative;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;

    logic       lat_valid = 1'b0;
    logic       lat_ir [4];
    logic       lat_ov [4];
    logic [7:0] lat_od [4];
    logic       lat_busy [4];

    int         checks = 0;
    int         failures = 0;
    logic [7:0] isb [256];

    always #5 clk = ~clk;

    inv_sbox_iterative #(.STEPS(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_lat
        inv_sbox_iterative #(.STEPS(1 << g)) u_lat (
            .clk(clk), .reset_n(reset_n), .in_valid(lat_valid), .in_ready(lat_ir[g]),
            .in_data(in_data), .out_valid(lat_ov[g]), .out_ready(1'b1),
            .out_data(lat_od[g]), .busy(lat_busy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int aa = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa << 1;
            if (aa > 255) aa = aa ^ 'h11B;
        end
        return 8'(p);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        int w = int'(v);
        return 8'(((w << n) | (w >> (8 - n))) & 255);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(out_valid), 1);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check("send_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int         n, sent, recv, last_out, cyc;
        int         first_lat [4];
        logic [7:0] lat_dat [4];
        logic [7:0] q [$];
        logic [7:0] hold_data;
        logic       hold, seen;

        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            isb[s] = 8'(a);
        end

        #3 reset_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        tick();
        #2 reset_n = 1'b1;
        tick();

        check("spot_63", 32'(isb[8'h63]), 32'h00);
        check("spot_7c", 32'(isb[8'h7C]), 32'h01);
        check("spot_00", 32'(isb[8'h00]), 32'h52);
        check("spot_16", 32'(isb[8'h16]), 32'hFF);
        check("spot_ed", 32'(isb[8'hED]), 32'h53);

        out_ready = 1'b1;
        for (int b = 0; b < 256; b++) begin
            send(8'(b));
            wait_out("exh", n);
            check($sformatf("exh_%02h", b), 32'(out_data), 32'(isb[b]));
            check("exh_latency", n, 8);
        end
        tick();

        in_data   = 8'hED;
        lat_valid = 1'b1;
        tick();
        lat_valid = 1'b0;
        in_data   = 8'h00;
        for (int g = 0; g < 4; g++) first_lat[g] = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            for (int g = 0; g < 4; g++)
                if (lat_ov[g] && first_lat[g] == 0) begin
                    first_lat[g] = k;
                    lat_dat[g]   = lat_od[g];
                end
        end
        for (int g = 0; g < 4; g++) begin
            check($sformatf("lat_cycles_steps%0d", 1 << g), first_lat[g], 8 >> g);
            check($sformatf("lat_data_steps%0d", 1 << g), 32'(lat_dat[g]), 32'h53);
        end

        out_ready = 1'b0;
        send(8'h16);
        wait_out("bp", n);
        in_valid = 1'b1;
        in_data  = 8'h63;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_data", 32'(out_data), 32'hFF);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_valid", 32'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'hAA;
        check("bp_consumed", 32'(out_valid), 0);
        check("bp_busy", 32'(busy), 1);
        wait_out("bp2", n);
        check("bp_next_data", 32'(out_data), 32'h00);
        check("bp_next_latency", n, 8);
        tick();

        q.delete();
        sent = 0; recv = 0; last_out = -1;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 400 && recv < 16; cyc++) begin
            in_valid = sent < 16;
            #1;
            if (in_valid && in_ready) begin
                q.push_back(isb[in_data]);
                sent++;
            end
            tick();
            if (out_valid) begin
                check("stream_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) check("stream_data", 32'(out_data), 32'(q.pop_front()));
                if (last_out >= 0) check("stream_spacing", cyc - last_out, 9);
                last_out = cyc;
                recv++;
            end
            in_data = 8'($urandom_range(0, 255));
        end
        in_valid = 1'b0;
        check("stream_count", recv, 16);
        tick();

        send(8'h7C);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_data", 32'(out_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        tick();
        #2 reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen = seen | out_valid;
        end
        check("mid_rst_no_output", 32'(seen), 0);
        send(8'h7C);
        wait_out("after_rst", n);
        check("after_rst_data", 32'(out_data), 32'h01);
        tick();

        q.delete();
        sent = 0; recv = 0; hold = 1'b0; hold_data = 8'h00;
        for (cyc = 0; cyc < 80000 && recv < 3000; cyc++) begin
            in_valid  = (sent < 3000) && ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            out_ready = $urandom_range(0, 2) != 0;
            #1;
            if (hold) begin
                check("rand_hold_valid", 32'(out_valid), 1);
                check("rand_hold_data", 32'(out_data), 32'(hold_data));
            end
            if (in_valid && in_ready) begin
                q.push_back(isb[in_data]);
                sent++;
            end
            if (out_valid && out_ready) begin
                check("rand_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) check("rand_data", 32'(out_data), 32'(q.pop_front()));
                recv++;
            end
            hold      = out_valid && !out_ready;
            hold_data = out_data;
            tick();
        end
        in_valid = 1'b0;
        check("rand_count", recv, 3000);
        check("rand_leftover", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
